dm_arb: RTL

DM_ARB -- requirements
Module: dm_arb

---
 rtl/dm_arb.sv | 113 +++++++++++
 1 files changed

// File: rtl/dm_arb.sv
// Two-port (CPU / debug) round-robin arbiter in front of a single-port word memory.
// Each accepted request gets one memory command cycle, and loads get one extra response cycle.
module dm_arb #(
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [31:0]   c_addr,
  input  logic [31:0]   c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [31:0]   c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata,
  output logic          misalign
);

  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

  state_t        state;
  logic          owner;       // 1 = debug port owns the current access
  logic          last_owner;  // 1 = debug port was served last
  logic          pick_d;
  logic          sel_we;
  logic [DW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          unused_addr_bits;

  // Debug wins when alone, or on a tie when the CPU was served last.
  always_comb begin
    pick_d    = d_req && (!c_req || !last_owner);
    sel_we    = pick_d ? d_we    : c_we;
    sel_addr  = pick_d ? d_addr  : c_addr;
    sel_wdata = pick_d ? d_wdata : c_wdata;
  end

  // High address bits are deliberately dropped so accesses wrap modulo the memory depth.
  assign unused_addr_bits = ^sel_addr[DW-1:AW+2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      m_en       <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      c_gnt      <= 1'b0;
      d_gnt      <= 1'b0;
      c_rvalid   <= 1'b0;
      d_rvalid   <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (c_req || d_req) begin
            owner      <= pick_d;
            last_owner <= pick_d;
            m_en       <= 1'b1;
            m_we       <= sel_we;
            m_addr     <= sel_addr[AW+1:2];
            m_wdata    <= sel_wdata;
            c_gnt      <= !pick_d;
            d_gnt      <= pick_d;
            if (sel_addr[1:0] != 2'b00) misalign <= 1'b1;
            state      <= ACC;
          end
        end
        ACC: begin
          m_en    <= 1'b0;
          m_we    <= 1'b0;
          m_addr  <= '0;
          m_wdata <= '0;
          c_gnt   <= 1'b0;
          d_gnt   <= 1'b0;
          if (m_we) begin
            state <= IDLE;
          end else begin
            c_rvalid <= !owner;
            d_rvalid <= owner;
            state    <= RESP;
          end
        end
        RESP: begin
          c_rvalid <= 1'b0;
          d_rvalid <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Load data is forwarded straight from memory during the response cycle only.
  assign c_rdata = c_rvalid ? m_rdata : '0;
  assign d_rdata = d_rvalid ? m_rdata : '0;

endmodule
